dut_bus_arbiter: RTL and testbench
==================================

// Module: dut_bus_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single dut valid/rw/addr/ready bus among NUM_REQ
//  requesters (generator/driver channels). Latches the winner's command, drives it on
//  the bus until ready, returns read data or a timeout error, then re-arbitrates.
// PARAMETERS
//  NUM_REQ  4   number of requesters (>=2)
//  ADDR_W   8   bus address width
//  DATA_W   32  bus data width
//  TIMEOUT  64  max bus cycles waiting for ready before abort; 0 = never abort
// PORTS
//  clk        in   1                clock, all logic on rising edge
//  rst_n      in   1                asynchronous active-low reset
//  req_valid  in   NUM_REQ          per-requester request, held until its req_ready
//  req_rw     in   NUM_REQ          per-requester 1=write, 0=read
//  req_addr   in   NUM_REQ*ADDR_W   packed, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata  in   NUM_REQ*DATA_W   packed, requester i at [i*DATA_W +: DATA_W]
//  req_ready  out  NUM_REQ          one-hot 1-cycle completion pulse
//  req_rdata  out  DATA_W           read data, valid while req_ready!=0
//  req_err    out  1                1 = timeout abort, valid while req_ready!=0
//  valid      out  1                bus command valid
//  rw         out  1                bus 1=write, 0=read
//  addr       out  ADDR_W           bus address
//  wdata      out  DATA_W           bus write data
//  ready      in   1                bus accept/complete
//  rdata      in   DATA_W           bus read data, sampled with ready
//  busy       out  1                state != IDLE
//  grant_id   out  $clog2(NUM_REQ)  index of current/last granted requester
// BEHAVIOUR
//  Reset (async, immediate): all outputs 0, state IDLE, RR pointer 0, timer 0.
//  FSM IDLE -> BUSY -> DONE -> IDLE; all outputs registered.
//  IDLE: if any req_valid, winner = first set bit at or after RR pointer (wrapping);
//   latch rw/addr/wdata, grant_id=winner, RR pointer=winner+1 mod NUM_REQ, ->BUSY.
//   None set: stay IDLE, outputs unchanged except valid=0.
//  BUSY: valid=1, rw/addr/wdata held stable from latch; requester payload changes
//   ignored. Timer counts BUSY cycles from 1.
//   ready=1 -> capture rdata (read) or 0 (write), err=0, ->DONE, valid=0 next cycle.
//   ready=0 and timer==TIMEOUT (TIMEOUT!=0) -> abort: rdata=0, err=1, ->DONE.
//   ready=1 in the timeout cycle: ready wins, normal completion.
//  DONE: one cycle, req_ready[grant_id]=1 with req_rdata/req_err; ->IDLE.
//   req_rdata/req_err return to 0 when req_ready is 0.
//  Latency: req_valid seen in IDLE at edge N -> valid high cycle N+1; ready at edge M
//   -> req_ready high cycle M+1; next bus valid no earlier than M+3.
//  Requester dropping req_valid before grant withdraws the request; dropping after grant
//   has no effect (transaction completes, req_ready still pulses).
//  Single requester: exactly one transaction per request; re-requests on req_valid seen
//   in IDLE only, after DONE.
//  busy=1 in BUSY and DONE; grant_id holds last winner in IDLE.
// TESTING
//  1 Read: req1 addr 0x10, ready 3 cycles after valid, rdata 0xDEADBEEF -> valid 3
//    cycles, addr 0x10 rw 0, req_ready=4'b0010 1 cycle, req_rdata 0xDEADBEEF, err 0.
//  2 All 4 req_valid held after reset, ready after 1 cycle -> grant order 0,1,2,3,0;
//    each req_ready one-hot matches grant_id.
//  3 TIMEOUT=8, ready tied 0 -> valid high exactly 8 cycles, then req_ready pulse,
//    req_err=1, req_rdata=0; next request proceeds normally.
//  4 TIMEOUT=8, ready=1 in 8th BUSY cycle -> normal completion, err 0, rdata captured.
//  5 Write req2 wdata 0x12345678 addr 0x3C, payload changed mid-BUSY -> bus holds
//    0x12345678/0x3C/rw 1; req_rdata=0 on completion.
//  6 rst_n low mid-BUSY -> valid/busy/req_ready 0 same cycle; after release with req0
//    and req2 pending -> req0 granted first.

Source files
------------

// File: rtl/dut_bus_arbiter.sv
// Round-robin arbiter that shares one valid/rw/addr/ready bus among NUM_REQ
// requesters. The winner's command is latched and driven until the bus answers
// or the timeout expires; the result is returned as a one-cycle req_ready pulse.
module dut_bus_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_rw,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]           req_rdata,
    output logic                        req_err,
    output logic                        valid,
    output logic                        rw,
    output logic [ADDR_W-1:0]           addr,
    output logic [DATA_W-1:0]           wdata,
    input  logic                        ready,
    input  logic [DATA_W-1:0]           rdata,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

    localparam int          IDX_W = $clog2(NUM_REQ);
    localparam int          TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned NR    = NUM_REQ;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic                 valid_q, valid_d;
    logic                 rw_q, rw_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic [DATA_W-1:0]    req_rdata_q, req_rdata_d;
    logic                 req_err_q, req_err_d;
    logic                 busy_q, busy_d;

    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     scan_idx;
    logic                 complete;
    logic                 abort;

    logic [ADDR_W-1:0]    addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]    wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    // State register and all registered outputs, async active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_q        <= '0;
            timer_q     <= '0;
            grant_q     <= '0;
            valid_q     <= 1'b0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_ready_q <= '0;
            req_rdata_q <= '0;
            req_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            timer_q     <= timer_d;
            grant_q     <= grant_d;
            valid_q     <= valid_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            req_rdata_q <= req_rdata_d;
            req_err_q   <= req_err_d;
            busy_q      <= busy_d;
        end
    end

    // Next state: round-robin winner search, bus timer, completion/abort decision
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        timer_d   = timer_q;
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        complete  = 1'b0;
        abort     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                for (int unsigned k = 0; k < NR; k++) begin
                    scan_idx = IDX_W'((32'(rr_q) + k) % NR);
                    if (!win_found && req_valid[scan_idx]) begin
                        win_found = 1'b1;
                        win_idx   = scan_idx;
                    end
                end
                if (win_found) begin
                    state_d = ST_BUSY;
                    rr_d    = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
                    timer_d = TMR_W'(1);
                end
            end
            ST_BUSY: begin
                if (ready) begin
                    complete = 1'b1;
                    state_d  = ST_DONE;
                end else if (TIMEOUT != 0 && timer_q == TMR_W'(TIMEOUT)) begin
                    abort   = 1'b1;
                    state_d = ST_DONE;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values loaded into the output registers at the next edge
    always_comb begin
        valid_d     = 1'b0;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        grant_d     = grant_q;
        req_ready_d = '0;
        req_rdata_d = '0;
        req_err_d   = 1'b0;
        busy_d      = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    valid_d = 1'b1;
                    rw_d    = req_rw[win_idx];
                    addr_d  = addr_arr[win_idx];
                    wdata_d = wdata_arr[win_idx];
                    grant_d = win_idx;
                end
            end
            ST_BUSY: begin
                if (complete) begin
                    req_ready_d[grant_q] = 1'b1;
                    req_rdata_d          = rw_q ? '0 : rdata;
                end else if (abort) begin
                    req_ready_d[grant_q] = 1'b1;
                    req_err_d            = 1'b1;
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign req_ready = req_ready_q;
    assign req_rdata = req_rdata_q;
    assign req_err   = req_err_q;
    assign valid     = valid_q;
    assign rw        = rw_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign busy      = busy_q;
    assign grant_id  = grant_q;

endmodule

// File: tb/tb_dut_bus_arbiter.sv
// Testbench for dut_bus_arbiter: table-driven single-requester transactions,
// a round-robin fairness sequence and a reset-during-transfer sequence.
module tb_dut_bus_arbiter;

    localparam int NR = 4;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_rw;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_ready;
    logic [DW-1:0]     req_rdata;
    logic              req_err;
    logic              valid;
    logic              rw;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     wdata;
    logic              ready;
    logic [DW-1:0]     rdata;
    logic              busy;
    logic [1:0]        grant_id;

    dut_bus_arbiter #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .req_rdata (req_rdata),
        .req_err   (req_err),
        .valid     (valid),
        .rw        (rw),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready),
        .rdata     (rdata),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        rw;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          ready_cyc;   // valid cycles before ready is seen; 0 = never
        logic [31:0] rdata;
        logic        scramble;    // change requester payload mid-transfer
        logic [3:0]  exp_ready;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_vcyc;
    } vec_t;

    typedef struct {
        logic [3:0]  rdy;
        logic [31:0] rdata;
        logic        err;
        int          vcyc;
        int          gid;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_txn(input vec_t v);
        exp_t e;
        int   vcyc;
        bit   done;
        @(negedge clk);
        req_valid[v.id]          = 1'b1;
        req_rw[v.id]             = v.rw;
        req_addr[v.id*AW +: AW]  = v.addr;
        req_wdata[v.id*DW +: DW] = v.wdata;
        rdata                    = v.rdata;
        e = '{rdy: v.exp_ready, rdata: v.exp_rdata, err: v.exp_err, vcyc: v.exp_vcyc, gid: v.id};
        sb.push_back(e);
        vcyc = 0;
        done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (valid) begin
                vcyc++;
                chk("bus_hold", {rw, addr, wdata}, {v.rw, v.addr, v.wdata});
                if (v.scramble && vcyc == 1) begin
                    req_rw[v.id]             = ~v.rw;
                    req_addr[v.id*AW +: AW]  = ~v.addr;
                    req_wdata[v.id*DW +: DW] = ~v.wdata;
                end
            end
            ready = valid && (v.ready_cyc != 0) && (vcyc == v.ready_cyc);
            if (req_ready != '0) begin
                e = sb.pop_front();
                chk("req_ready", req_ready, e.rdy);
                chk("req_rdata", req_rdata, e.rdata);
                chk("req_err",   req_err,   e.err);
                chk("valid_cycles", vcyc, e.vcyc);
                chk("grant_id",  grant_id,  e.gid);
                req_valid[v.id] = 1'b0;
                done = 1;
            end
        end
        ready = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL txn_timeout: got no req_ready required a pulse (req %0d)", v.id);
            req_valid[v.id] = 1'b0;
            if (sb.size() != 0) void'(sb.pop_front());
        end
        // exactly one transaction per request, and return data cleared after the pulse
        for (int q = 0; q < 3; q++) begin
            @(negedge clk);
            chk("idle_quiet", {valid, busy, req_ready, req_err, req_rdata}, '0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   ncomp;

        vecs[0] = '{id: 1, rw: 1'b0, addr: 8'h10, wdata: 32'h0, ready_cyc: 3, rdata: 32'hDEADBEEF, scramble: 1'b0,
                    exp_ready: 4'b0010, exp_rdata: 32'hDEADBEEF, exp_err: 1'b0, exp_vcyc: 3};
        vecs[1] = '{id: 3, rw: 1'b0, addr: 8'h80, wdata: 32'h0, ready_cyc: 0, rdata: 32'hAAAA5555, scramble: 1'b0,
                    exp_ready: 4'b1000, exp_rdata: 32'h0, exp_err: 1'b1, exp_vcyc: 8};
        vecs[2] = '{id: 0, rw: 1'b0, addr: 8'h44, wdata: 32'h0, ready_cyc: 1, rdata: 32'h0BADF00D, scramble: 1'b0,
                    exp_ready: 4'b0001, exp_rdata: 32'h0BADF00D, exp_err: 1'b0, exp_vcyc: 1};
        vecs[3] = '{id: 2, rw: 1'b0, addr: 8'h21, wdata: 32'h0, ready_cyc: 8, rdata: 32'hCAFEF00D, scramble: 1'b0,
                    exp_ready: 4'b0100, exp_rdata: 32'hCAFEF00D, exp_err: 1'b0, exp_vcyc: 8};
        vecs[4] = '{id: 2, rw: 1'b1, addr: 8'h3C, wdata: 32'h12345678, ready_cyc: 4, rdata: 32'hFFFFFFFF, scramble: 1'b1,
                    exp_ready: 4'b0100, exp_rdata: 32'h0, exp_err: 1'b0, exp_vcyc: 4};
        vecs[5] = '{id: 3, rw: 1'b1, addr: 8'hFF, wdata: 32'h00000000, ready_cyc: 5, rdata: 32'h00000001, scramble: 1'b0,
                    exp_ready: 4'b1000, exp_rdata: 32'h0, exp_err: 1'b0, exp_vcyc: 5};

        rst_n     = 1'b0;
        req_valid = '0;
        req_rw    = '0;
        req_addr  = '0;
        req_wdata = '0;
        ready     = 1'b0;
        rdata     = '0;

        // reset state
        repeat (2) @(negedge clk);
        chk("reset_ret", {req_ready, req_rdata, req_err}, '0);
        chk("reset_bus", {valid, rw, addr, wdata, busy, grant_id}, '0);
        rst_n = 1'b1;

        // all four requesters held: grant order 0,1,2,3,0
        @(negedge clk);
        req_valid = 4'hF;
        req_addr  = 32'h40302010;
        for (int k = 0; k < 5; k++) begin
            e = '{rdy: 4'b0001 << (k % 4), rdata: 32'h0, err: 1'b0, vcyc: 1, gid: k % 4};
            sb.push_back(e);
        end
        ncomp = 0;
        for (int c = 0; c < 100 && ncomp < 5; c++) begin
            @(negedge clk);
            ready = valid;
            if (req_ready != '0) begin
                e = sb.pop_front();
                chk("rr_ready", req_ready, e.rdy);
                chk("rr_grant", grant_id, e.gid);
                ncomp++;
                if (ncomp == 5) req_valid = '0;
            end
        end
        ready = 1'b0;
        if (ncomp != 5) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rr_timeout: got %0d completions required 5", ncomp);
            sb.delete();
        end
        req_addr = '0;

        // table-driven single-requester transactions
        for (int i = 0; i < 6; i++) do_txn(vecs[i]);

        // reset asserted in the middle of a transfer
        @(negedge clk);
        req_valid[1]      = 1'b1;
        req_addr[15:8]    = 8'h55;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", {busy, valid, grant_id}, {1'b1, 1'b1, 2'd1});
        #2 rst_n = 1'b0;
        #1 chk("rst_async", {valid, busy, req_ready, grant_id}, '0);
        req_valid = 4'b0101;
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back('{rdy: 4'b0001, rdata: 32'h0, err: 1'b0, vcyc: 1, gid: 0});
        sb.push_back('{rdy: 4'b0100, rdata: 32'h0, err: 1'b0, vcyc: 1, gid: 2});
        ncomp = 0;
        for (int c = 0; c < 60 && ncomp < 2; c++) begin
            @(negedge clk);
            ready = valid;
            if (req_ready != '0) begin
                e = sb.pop_front();
                chk("post_rst_ready", req_ready, e.rdy);
                chk("post_rst_grant", grant_id, e.gid);
                req_valid[e.gid] = 1'b0;
                ncomp++;
            end
        end
        ready = 1'b0;
        if (ncomp != 2) begin
            n_cmp++;
            n_bad++;
            $display("FAIL post_rst_timeout: got %0d completions required 2", ncomp);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
